stream_round_robin_arbiter: RTL
===============================

// Module: stream_round_robin_arbiter
// PURPOSE
//  Merges INPUT_COUNT ready/valid word streams into one output stream with round-robin fairness.
//  Sits upstream of a skidbuffer that drives a shared datapath; that skidbuffer breaks the combinational ready path.
//  One word is transferred per cycle at full throughput. Each output word is tagged with the index of the input it came from.
// PARAMETERS
//  WORD_WIDTH   8  data bits per word
//  INPUT_COUNT  4  number of requesting input streams, >= 2
//  SOURCE_WIDTH (localparam) = clog2(INPUT_COUNT); width of output_source
// PORTS
//  clock          in   1                         single clock, all logic on rising edge
//  clear          in   1                         reset, asynchronous, active-high
//  input_valid    in   INPUT_COUNT               per-input valid, bit i = input i
//  input_ready    out  INPUT_COUNT               per-input ready, combinational
//  input_data     in   INPUT_COUNT*WORD_WIDTH    input i occupies bits [i*WORD_WIDTH +: WORD_WIDTH]
//  input_last     in   INPUT_COUNT               per-input end-of-packet flag
//  output_valid   out  1                         output register holds a word
//  output_ready   in   1                         downstream accepts the word
//  output_data    out  WORD_WIDTH                registered word
//  output_last    out  1                         registered last flag of the word
//  output_source  out  SOURCE_WIDTH              registered index of the originating input
// BEHAVIOUR
//  - Reset (async, clear=1): output_valid=0, output_data=0, output_last=0, output_source=0.
//    Pointer prev_grant=INPUT_COUNT-1, so input 0 has top priority first. lock=0.
//    clear asserted mid-transfer discards the held word immediately. No partial packet survives.
//  - accept = !output_valid || output_ready (output register free or emptying this cycle).
//  - Grant (combinational, one-hot or zero):
//    - Lowest-offset valid input, searching prev_grant+1, +2, ... with wrap modulo INPUT_COUNT.
//    - prev_grant itself is checked last. No valid inputs gives a zero grant.
//  - input_ready[i] = grant[i] && accept. At most one bit is high per cycle. input_ready never depends on input_valid of input i alone.
//  - Transfer in: (input_valid & input_ready) != 0. On that edge:
//    - output_data/last/source load from the granted input; output_valid=1.
//    - prev_grant is set to the granted index.
//  - Output removed with no transfer in (output_valid && output_ready, no grant): output_valid=0; data/last/source hold their values.
//  - Simultaneous remove and insert in the same cycle: the new word replaces the old one, output_valid stays 1 (flow, no bubble).
//  - output_valid=1 && output_ready=0: all input_ready=0; output_* stable until accepted.
//  - Latency: input handshake to output_valid is 1 cycle. Sustained throughput is 1 word/cycle.
//  - Fairness: with all inputs continuously valid, the grant order is 0,1,...,N-1,0,... and each input waits at most INPUT_COUNT-1 transfers.
//  - Wrap-around: prev_grant=INPUT_COUNT-1 searches from index 0. prev_grant is updated only on a transfer, never on idle cycles.
//  - output_last always propagates input_last unchanged, regardless of configuration.
// CONFIGURATION
//  STREAM_ROUND_ROBIN_ARBITER_LOCK_EN defined: packet lock.
//    - A transfer with input_last=0 sets lock=1. While locked, grant is forced to prev_grant only.
//    - If the locked input drops valid, bubbles result; other inputs are not granted.
//    - A transfer with input_last=1 from the locked input clears lock. Normal round-robin resumes from prev_grant+1.
//    - clear always releases the lock.
//  Macro undefined: no lock register. Arbitration is per word; packets from different inputs may interleave on the output.
// TESTING
//  1. Assert clear, then all input_valid=0 -> output_valid=0, input_ready=0000, output_data=0, output_source=0.
//  2. Inputs 0 and 2 valid continuously, output_ready=1 -> output_source 0,2,0,2 on consecutive cycles; output_valid held 1.
//  3. All 4 inputs valid, output_ready=1 -> sources 0,1,2,3,0; then input 3 alone valid after a grant of 3 -> next source 3 (wrap, sole requester).
//  4. Word 0xA5 from input 1 held, output_ready=0 for 5 cycles -> output_data=0xA5 stable, input_ready=0000; output_ready=1 -> next word next cycle.
//  5. LOCK_EN defined: input 1 sends 3 words (last on 3rd), input 3 valid throughout -> sources 1,1,1,3. Macro undefined -> 1,3,1,3,1.
//  6. clear pulsed while output_valid=1 and lock=1 -> output_valid=0 same cycle (async). After release, inputs 0 and 1 valid -> first source 0.

Source files
------------

// File: rtl/stream_round_robin_arbiter.sv
// stream_round_robin_arbiter: round-robin merge of ready/valid word streams into one registered, source-tagged output.
// Define STREAM_ROUND_ROBIN_ARBITER_LOCK_EN to hold the grant on one input until its last word.
module stream_round_robin_arbiter #(
  parameter int WORD_WIDTH = 8,
  parameter int INPUT_COUNT = 4,
  localparam int SOURCE_WIDTH = $clog2(INPUT_COUNT)
) (
  input  logic                              clock,
  input  logic                              clear,
  input  logic [INPUT_COUNT-1:0]            input_valid,
  output logic [INPUT_COUNT-1:0]            input_ready,
  input  logic [INPUT_COUNT*WORD_WIDTH-1:0] input_data,
  input  logic [INPUT_COUNT-1:0]            input_last,
  output logic                              output_valid,
  input  logic                              output_ready,
  output logic [WORD_WIDTH-1:0]             output_data,
  output logic                              output_last,
  output logic [SOURCE_WIDTH-1:0]           output_source
);
  logic                    valid_q, last_q, accept, found, xfer;
  logic [WORD_WIDTH-1:0]   data_q;
  logic [SOURCE_WIDTH-1:0] src_q, prev_q, grant_idx, idx;
  logic [INPUT_COUNT-1:0]  grant;
`ifdef STREAM_ROUND_ROBIN_ARBITER_LOCK_EN
  logic lock_q;
`endif
  assign accept = !valid_q || output_ready;
  // search starts just after the last winner, so prev_q itself is the final candidate
  always_comb begin
    found = 1'b0;
    grant_idx = '0;
    idx = '0;
    for (int k = 1; k <= INPUT_COUNT; k++) begin
      idx = SOURCE_WIDTH'((int'(prev_q) + k) % INPUT_COUNT);
      if (!found && input_valid[idx]) begin
        found = 1'b1;
        grant_idx = idx;
      end
    end
`ifdef STREAM_ROUND_ROBIN_ARBITER_LOCK_EN
    if (lock_q) begin
      found = input_valid[prev_q];
      grant_idx = prev_q;
    end
`endif
    grant = found ? INPUT_COUNT'(1) << grant_idx : '0;
  end
  assign input_ready = accept ? grant : '0;
  assign xfer = found && accept;
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      valid_q <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
      src_q <= '0;
      prev_q <= SOURCE_WIDTH'(INPUT_COUNT - 1);
`ifdef STREAM_ROUND_ROBIN_ARBITER_LOCK_EN
      lock_q <= 1'b0;
`endif
    end else if (xfer) begin
      valid_q <= 1'b1;
      data_q <= input_data[grant_idx*WORD_WIDTH +: WORD_WIDTH];
      last_q <= input_last[grant_idx];
      src_q <= grant_idx;
      prev_q <= grant_idx;
`ifdef STREAM_ROUND_ROBIN_ARBITER_LOCK_EN
      lock_q <= !input_last[grant_idx];
`endif
    end else if (output_ready) begin
      valid_q <= 1'b0;
    end
  end
  assign output_valid = valid_q;
  assign output_data = data_q;
  assign output_last = last_q;
  assign output_source = src_q;
endmodule
